// File: rtl/mem_responder.sv
// Backing-memory responder for the cache controller m2s bus.
// Programmable read/write wait states, one-cycle ack/err pulse.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 200,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_m2s_i,
  input  logic              we_m2s_i,
  input  logic [ADDR_W-1:0] adr_m2s_i,
  input  logic [DATA_W-1:0] dat_m2s_i,
  output logic [DATA_W-1:0] dat_mem_o,
  output logic              ack_mem_o,
  output logic              err_mem_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_idle;
  logic [3:0]        w_load;
  logic              w_commit;
  logic              w_we;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_dat;
  logic              w_inr;
  logic [DATA_W-1:0] w_rdata;

  // Commit happens on the edge that enters RESP; a zero-wait
  // request commits straight from IDLE using the live inputs.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_load   = we_m2s_i ? 4'(WR_WAIT) : 4'(RD_WAIT);
    w_commit = (w_idle && cyc_m2s_i && (w_load == 4'd0))
            || ((r_state == S_WAIT) && cyc_m2s_i
                && (r_cnt == 4'd1));
    w_we     = w_idle ? we_m2s_i  : r_we;
    w_adr    = w_idle ? adr_m2s_i : r_adr;
    w_dat    = w_idle ? dat_m2s_i : r_dat;
    w_inr    = (32'(w_adr) < 32'(DEPTH));
    w_rdata  = '0;
    if (w_inr) begin
      w_rdata = r_mem[w_adr];
    end
  end

  // Array write; contents survive reset, held off while in reset.
  always_ff @(posedge clk) begin
    if (rst && w_commit && w_we && w_inr) begin
      r_mem[w_adr] <= w_dat;
    end
  end

  // Request FSM, wait counter and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      dat_mem_o <= '0;
      ack_mem_o <= 1'b0;
      err_mem_o <= 1'b0;
    end else begin
      ack_mem_o <= 1'b0;
      err_mem_o <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cyc_m2s_i) begin
            r_we    <= we_m2s_i;
            r_adr   <= adr_m2s_i;
            r_dat   <= dat_m2s_i;
            r_cnt   <= w_load;
            r_state <= (w_load == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cyc_m2s_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
      if (w_commit) begin
        ack_mem_o <= w_inr;
        err_mem_o <= !w_inr;
        if (!w_inr) begin
          dat_mem_o <= '0;
        end else if (w_we) begin
          dat_mem_o <= w_dat;
        end else begin
          dat_mem_o <= w_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default-wait and
// zero-wait instances sharing one stimulus bus.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cyc = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] dat = 8'h00;
  logic [7:0] d0, d1;
  logic       a0, e0, a1, e1;
  logic       pa0 = 1'b0;
  logic       pa1 = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mem_responder u0 (
    .clk(clk), .rst(rst),
    .cyc_m2s_i(cyc), .we_m2s_i(we),
    .adr_m2s_i(adr), .dat_m2s_i(dat),
    .dat_mem_o(d0), .ack_mem_o(a0), .err_mem_o(e0)
  );

  mem_responder #(.RD_WAIT(0), .WR_WAIT(0)) u1 (
    .clk(clk), .rst(rst),
    .cyc_m2s_i(cyc), .we_m2s_i(we),
    .adr_m2s_i(adr), .dat_m2s_i(dat),
    .dat_mem_o(d1), .ack_mem_o(a1), .err_mem_o(e1)
  );

  typedef struct {
    logic       cyc;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
    logic       ack;
    logic       err;
    logic [7:0] rd;
    string      nm;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    input logic c, input logic w,
    input logic [7:0] a, input logic [7:0] d,
    input logic k, input logic e,
    input logic [7:0] r, input string n);
    vec_t v;
    v.cyc = c; v.we = w; v.adr = a; v.dat = d;
    v.ack = k; v.err = e; v.rd = r; v.nm = n;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w,
                       input logic [7:0] a,
                       input logic [7:0] d);
    @(negedge clk);
    cyc = c; we = w; adr = a; dat = d;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.cyc, v.we, v.adr, v.dat);
    edge1();
    chk({v.nm, "_ack"}, {7'd0, a0}, {7'd0, v.ack});
    chk({v.nm, "_err"}, {7'd0, e0}, {7'd0, v.err});
    chk({v.nm, "_dat"}, d0, v.rd);
  endtask

  // Pulse width and ack/err exclusivity on both instances.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((a0 && e0) || (a1 && e1)) begin
        errors++;
        $display("FAIL ackerr_excl: u0 %b%b u1 %b%b required not both",
                 a0, e0, a1, e1);
      end
      if ((a0 && pa0) || (a1 && pa1)) begin
        errors++;
        $display("FAIL ack_width: ack high 2 cycles, required 1");
      end
      pa0 = a0;
      pa1 = a1;
    end else begin
      pa0 = 1'b0;
      pa1 = 1'b0;
    end
  end

  initial begin
    // T1 write/read with wait states, latched inputs
    add(1,1,8'h05,8'h3C, 0,0,8'h00, "t1_w05_s");
    add(1,1,8'h05,8'hFF, 1,0,8'h3C, "t1_w05_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h3C, "t1_w05_end");
    add(1,1,8'h06,8'h5A, 0,0,8'h3C, "t1_w06_s");
    add(1,1,8'h06,8'h5A, 1,0,8'h5A, "t1_w06_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h5A, "t1_w06_end");
    add(1,0,8'h05,8'h00, 0,0,8'h5A, "t1_r05_s");
    add(1,0,8'h07,8'h00, 0,0,8'h5A, "t1_r05_w1");
    add(1,0,8'h07,8'h00, 1,0,8'h3C, "t1_r05_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h3C, "t1_r05_end");
    // T2 out of range at DEPTH, last word in range
    add(1,0,8'hC8,8'h00, 0,0,8'h3C, "t2_rC8_s");
    add(1,0,8'hC8,8'h00, 0,0,8'h3C, "t2_rC8_w1");
    add(1,0,8'hC8,8'h00, 0,1,8'h00, "t2_rC8_err");
    add(0,0,8'h00,8'h00, 0,0,8'h00, "t2_rC8_end");
    add(1,1,8'hC7,8'hE1, 0,0,8'h00, "t2_wC7_s");
    add(1,1,8'hC7,8'hE1, 1,0,8'hE1, "t2_wC7_ack");
    add(0,0,8'h00,8'h00, 0,0,8'hE1, "t2_wC7_end");
    // T3 aborted write leaves prior content
    add(1,1,8'h10,8'h55, 0,0,8'hE1, "t3_w10_s");
    add(1,1,8'h10,8'h55, 1,0,8'h55, "t3_w10_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h55, "t3_w10_end");
    add(1,1,8'h10,8'hAA, 0,0,8'h55, "t3_ab_s");
    add(0,1,8'h10,8'hAA, 0,0,8'h55, "t3_ab_drop");
    add(0,0,8'h00,8'h00, 0,0,8'h55, "t3_ab_idle");
    add(1,0,8'h05,8'h00, 0,0,8'h55, "t3_r05_s");
    add(1,0,8'h05,8'h00, 0,0,8'h55, "t3_r05_w1");
    add(1,0,8'h05,8'h00, 1,0,8'h3C, "t3_r05_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h3C, "t3_r05_end");
    add(1,0,8'h10,8'h00, 0,0,8'h3C, "t3_r10_s");
    add(1,0,8'h10,8'h00, 0,0,8'h3C, "t3_r10_w1");
    add(1,0,8'h10,8'h00, 1,0,8'h55, "t3_r10_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h55, "t3_r10_end");
    // aborted read on its last wait edge
    add(1,0,8'h05,8'h00, 0,0,8'h55, "rab_s");
    add(1,0,8'h05,8'h00, 0,0,8'h55, "rab_w1");
    add(0,0,8'h05,8'h00, 0,0,8'h55, "rab_drop");
    add(0,0,8'h00,8'h00, 0,0,8'h55, "rab_idle1");
    add(0,0,8'h00,8'h00, 0,0,8'h55, "rab_idle2");
    // T4 cyc held high across write then read
    add(1,1,8'h01,8'h11, 0,0,8'h55, "t4_w_s");
    add(1,1,8'h01,8'h11, 1,0,8'h11, "t4_w_ack");
    add(1,0,8'h01,8'h00, 0,0,8'h11, "t4_bubble");
    add(1,0,8'h01,8'h00, 0,0,8'h11, "t4_r_s");
    add(1,0,8'h01,8'h00, 0,0,8'h11, "t4_r_w1");
    add(1,0,8'h01,8'h00, 1,0,8'h11, "t4_r_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h11, "t4_end");

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {7'd0, a0}, 8'd0);
    chk("rst_err", {7'd0, e0}, 8'd0);
    chk("rst_dat", d0, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[i]) run_vec(tv[i]);

    // T5 reset mid-WAIT of a read
    drive(1, 0, 8'h05, 8'h00);
    edge1();
    edge1();
    #2 rst = 1'b0;
    #1;
    chk("t5_async_dat", d0, 8'h00);
    chk("t5_async_ack", {7'd0, a0}, 8'd0);
    chk("t5_async_err", {7'd0, e0}, 8'd0);
    @(negedge clk);
    cyc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      edge1();
      chk("t5_noack", {6'd0, a0, e0}, 8'd0);
    end

    // T5 reset mid-WAIT of a write drops it
    drive(1, 1, 8'h05, 8'h99);
    edge1();
    #2 rst = 1'b0;
    #1;
    chk("t5w_async_dat", d0, 8'h00);
    @(negedge clk);
    cyc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tv.delete();
    add(1,0,8'h05,8'h00, 0,0,8'h00, "t5w_r_s");
    add(1,0,8'h05,8'h00, 0,0,8'h00, "t5w_r_w1");
    add(1,0,8'h05,8'h00, 1,0,8'h3C, "t5w_r_ack");
    add(0,0,8'h00,8'h00, 0,0,8'h3C, "t5w_r_end");
    foreach (tv[i]) run_vec(tv[i]);

    // T6 zero-wait instance
    drive(1, 1, 8'h20, 8'h77);
    edge1();
    chk("t6_w_ack", {7'd0, a1}, 8'd1);
    chk("t6_w_dat", d1, 8'h77);
    drive(0, 0, 8'h00, 8'h00);
    edge1();
    chk("t6_w_end", {7'd0, a1}, 8'd0);
    drive(1, 0, 8'h20, 8'h00);
    edge1();
    chk("t6_r1_ack", {7'd0, a1}, 8'd1);
    chk("t6_r1_dat", d1, 8'h77);
    edge1();
    chk("t6_bubble", {7'd0, a1}, 8'd0);
    edge1();
    chk("t6_r2_ack", {7'd0, a1}, 8'd1);
    drive(1, 0, 8'hFF, 8'h00);
    edge1();
    chk("t6_rff_bub", {6'd0, a1, e1}, 8'd0);
    edge1();
    chk("t6_rff_err", {7'd0, e1}, 8'd1);
    chk("t6_rff_ack", {7'd0, a1}, 8'd0);
    chk("t6_rff_dat", d1, 8'h00);
    drive(0, 0, 8'h00, 8'h00);
    edge1();
    chk("t6_rff_end", {6'd0, a1, e1}, 8'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
